// File: rtl/multdiv_if.sv
// Operand, start and result signals exchanged between the pipeline and multdiv_unit.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide, one bit per cycle.
// Optional MULTDIV_FLUSH_EN adds a flush input that aborts the operation in flight.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MUL   | WIDTH shift-add iterations, then finalize product and overflow
// DIV   | WIDTH restoring iterations on magnitudes, then apply sign
// DONE  | result registered, data_resultRDY high for this cycle
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
`ifdef MULTDIV_FLUSH_EN
    input  logic     flush,
`endif
    multdiv_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_END  = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_SIGN = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   b_mag;

    logic               flush_req;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     prod_hi;
    logic               mul_ovf;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   div_res;

`ifdef MULTDIV_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // The magnitude of the signed minimum is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag_in = bus.data_operandA[WIDTH-1] ? ('0 - bus.data_operandA) : bus.data_operandA;
    assign b_mag_in = bus.data_operandB[WIDTH-1] ? ('0 - bus.data_operandB) : bus.data_operandB;

    // Multiplier sign bit carries weight -2^(WIDTH-1), so the last step subtracts.
    assign prod_next = !mplier[0]         ? prod :
                       (cnt == CNT_SIGN)  ? prod - mcand :
                                            prod + mcand;
    assign prod_hi   = prod[2*WIDTH-1:WIDTH-1];
    assign mul_ovf   = (|prod_hi) && !(&prod_hi);

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_mag};
    assign rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

    assign div_zero = (op_b == '0);
    assign div_ovf  = (op_a == SMIN) && (op_b == '1);
    assign div_res  = div_zero                        ? '0 :
                      (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? ('0 - quo) :
                                                        quo;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (flush_req) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.ctrl_MULT) begin
            state  <= MUL;
            cnt    <= '0;
            op_a   <= bus.data_operandA;
            op_b   <= bus.data_operandB;
            prod   <= '0;
            mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
            mplier <= bus.data_operandB;
        end else if (bus.ctrl_DIV) begin
            state <= DIV;
            cnt   <= '0;
            op_a  <= bus.data_operandA;
            op_b  <= bus.data_operandB;
            rem   <= '0;
            quo   <= a_mag_in;
            b_mag <= b_mag_in;
        end else begin
            case (state)
                MUL: begin
                    if (cnt == CNT_END) begin
                        result_q <= prod[WIDTH-1:0];
                        exc_q    <= mul_ovf;
                        state    <= DONE;
                    end else begin
                        prod   <= prod_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == CNT_END) begin
                        result_q <= div_res;
                        exc_q    <= div_zero | div_ovf;
                        state    <= DONE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state == MUL) || (state == DIV);

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits; legal range 8..64.
REQ-002 Port: clock  input  1  master clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: data_operandA  input  WIDTH  signed multiplicand or dividend.
REQ-005 Port: data_operandB  input  WIDTH  signed multiplier or divisor.
REQ-006 Port: ctrl_MULT  input  1  single-cycle start pulse for multiply.
REQ-007 Port: ctrl_DIV  input  1  single-cycle start pulse for divide.
REQ-008 Port: data_result  output  WIDTH  signed product (low WIDTH bits) or quotient.
REQ-009 Port: data_exception  output  1  overflow or divide-by-zero flag for data_result.
REQ-010 Port: data_resultRDY  output  1  one-cycle completion strobe.
REQ-011 Port: busy  output  1  high while an operation is in flight; the pipeline stalls on it.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-013 On a clock edge with ctrl_MULT=1, the block SHALL latch both operands, clear the iteration counter and enter MUL from any state.
REQ-014 On a clock edge with ctrl_DIV=1 and ctrl_MULT=0, the block SHALL latch both operands, clear the iteration counter and enter DIV from any state.
REQ-015 If ctrl_MULT and ctrl_DIV are both high on the same edge, multiply SHALL win.
REQ-016 A start pulse arriving mid-operation SHALL abandon the current operation without any strobe and restart with the new operands.
REQ-017 MUL SHALL perform signed shift-add (radix-2) multiplication, one iteration per cycle, for exactly WIDTH iterations.
REQ-018 DIV SHALL perform restoring division on operand magnitudes for exactly WIDTH iterations, then apply the sign, truncating toward zero; the remainder is discarded.
REQ-019 Latency: the start-sampling edge is edge 0; the FSM SHALL enter DONE at edge WIDTH+1; data_resultRDY SHALL be high only during that DONE cycle.
REQ-020 From DONE the FSM SHALL return to IDLE on the next edge unless a start pulse is present.
REQ-021 busy SHALL be high in MUL and DIV and low in IDLE and DONE.
REQ-022 data_result and data_exception SHALL update only on entry to DONE and hold until the next DONE entry or reset.
REQ-023 Multiply: if the full 2*WIDTH signed product does not sign-extend from bit WIDTH-1, data_exception SHALL be 1; data_result is always the low WIDTH bits.
REQ-024 Divide by zero SHALL give data_result=0 and data_exception=1.
REQ-025 Signed minimum divided by -1 SHALL give data_result=signed minimum and data_exception=1.
REQ-026 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-027 With reset high at an edge, the FSM SHALL go to IDLE, the counter to 0, and data_result, data_exception, data_resultRDY and busy to 0, overriding any simultaneous start pulse.
REQ-028 Reset during MUL or DIV SHALL abort the operation with no strobe.

Configuration
REQ-029 Macro MULTDIV_FLUSH_EN: when defined, the block SHALL add port flush (input, 1), which aborts the current operation on the next edge and returns the FSM to IDLE with no strobe and outputs held; flush SHALL have priority over start pulses. When the macro is undefined, the port SHALL be absent and only reset or a new start can abort.

Verification (WIDTH=32)
REQ-030 ctrl_MULT with A=7, B=-3 -> data_result=0xFFFFFFEB, data_exception=0, data_resultRDY high exactly at edge 33 only.
REQ-031 ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-032 ctrl_DIV with A=-21, B=4 -> data_result=0xFFFFFFFB (-5), data_exception=0; with A=5, B=0 -> data_result=0, data_exception=1; with A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1.
REQ-033 ctrl_MULT with 6*7, then ctrl_DIV with 100/7 at edge 10 -> no strobe for the multiply, strobe at edge 43 with data_result=14.
REQ-034 Reset at edge 15 of a multiply -> busy=0 at edge 15, no strobe ever, outputs 0; a following ctrl_MULT with 2*3 -> data_result=6.
REQ-035 With MULTDIV_FLUSH_EN defined, flush at edge 5 of a divide -> IDLE, no strobe, previous data_result retained.
